ctrl_decode_fsm: RTL and testbench
==================================

Name: ctrl_decode_fsm

Overview:
- Multi-cycle control unit for the 16-bit RISC datapath.
- Fetches instructions over a valid/request handshake and decodes them into register addresses, the 3-bit ALU function select, and write-back/memory controls.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- It is the producer of the FS code that the ALU consumes: the ALU is the receiving end of this interface, this block is the sending end.

Parameters:
- PC_WIDTH, 8, instruction address width; PC wraps modulo 2^PC_WIDTH.
- nBit, 16, instruction and data width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_req  out  1  instruction fetch request.
- instr_addr  out  PC_WIDTH  fetch address (current PC).
- instr_valid  in  1  instr_in valid this cycle.
- instr_in  in  nBit  fetched instruction.
- fs  out  3  ALU function select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT.
- rd_addr  out  3  destination register.
- rs_addr  out  3  ALU A operand register.
- rt_addr  out  3  ALU B operand register.
- imm  out  nBit  zero-extended instr[7:0].
- wb_sel  out  2  write-back source: 00 ALU, 01 imm, 10 memory.
- reg_we  out  1  register file write strobe, one cycle.
- mem_req  out  1  data memory request.
- mem_we  out  1  data memory write (valid with mem_req).
- mem_ready  in  1  data memory completes this cycle.
- alu_zero  in  1  combinational ALU output == 0.
- halted  out  1  core stopped.
- illegal  out  1  sticky, undefined opcode seen.

Behaviour:
- Reset is synchronous and active-high: on any rising clk edge with rst=1, all state is cleared regardless of the current state.
  - state=FETCH, PC=RESET_PC.
  - All outputs 0, including halted and illegal.
  - Any pending request is dropped; the requester must tolerate this.
- Instruction format:
  - [15:12] opcode, [11:9] rd, [8:6] rs, [5:3] rt, [7:0] imm8.
- Opcodes:
  - 0000 NOP.
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 NOT (rd <= op(rs,rt)).
  - 0111 LDI: rd <= imm.
  - 1000 LD: rd <= mem[rs].
  - 1001 ST: mem[rs] <= rt.
  - 1010 JMP: PC <= imm8.
  - 1011 BZ: if reg[rd field]==0 then PC <= imm8.
  - 1111 HALT.
  - Others are illegal.
- FETCH:
  - instr_req=1 and instr_addr=PC, held until instr_valid=1.
  - On that edge: latch IR, PC <= PC+1 (wraps), go to DECODE.
  - Zero-wait fetch means FETCH lasts exactly 1 cycle.
- DECODE (1 cycle):
  - Register rd/rs/rt/imm/fs from IR.
  - BZ: rs_addr=rt_addr=IR[11:9], fs=OR, so the ALU output equals the tested register.
  - LD/ST: address register presented on rs_addr.
  - fs for non-ALU ops = 000.
- EXEC (1 cycle):
  - ALU ops, LDI → WB.
  - LD/ST → MEM.
  - JMP: PC <= imm8[PC_WIDTH-1:0] → FETCH.
  - BZ: sample alu_zero; if 1, PC <= imm8, else PC unchanged → FETCH.
  - NOP → FETCH.
  - HALT → HALT.
  - Illegal: illegal <= 1, treated as NOP.
- MEM:
  - mem_req=1 (mem_we=1 for ST), held until mem_ready=1.
  - LD → WB; ST → FETCH.
- WB (1 cycle):
  - reg_we=1 with wb_sel set (ALU ops 00, LDI 01, LD 10) → FETCH.
  - reg_we is never asserted in any other state.
- HALT:
  - halted=1, no requests issued; exits only on rst.
- CPI: 4 for ALU/LDI, 3 for NOP/JMP/BZ, 4+ for ST and 5+ for LD (plus memory wait cycles), all assuming zero-wait fetch.
- rd/rs/rt/fs/imm/wb_sel stay stable from DECODE until the next DECODE.

Optional Feature:
- CTRL_RETIRE_CNT_EN defined:
  - Adds output retire_cnt (16 bits).
  - Increments on the last cycle of every completed instruction, including NOP, BZ not-taken and HALT.
  - Wraps FFFF→0000; reset to 0.
- CTRL_RETIRE_CNT_EN undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: rst=1 for 2 cycles, then release → instr_req=1 and instr_addr=00 next cycle; all other outputs 0.
- ADD r1,r2,r3 (0x1298), instr_valid immediate → fs=000, rs_addr=2, rt_addr=3, rd_addr=1; reg_we=1 with wb_sel=00 exactly once, 4 cycles after the fetch edge; next instr_addr=01.
- LD r4,[r5] (0x8940) with mem_ready delayed 3 cycles → mem_req held 4 cycles with mem_we=0, then one reg_we with wb_sel=10, rd_addr=4.
- BZ r2,0x40 (0xB440): with alu_zero=1, next instr_addr=0x40; with alu_zero=0, next instr_addr=PC+1; reg_we=0 in both cases.
- Opcode 0xC000 then HALT 0xF000 → illegal=1 and stays high; halted=1; instr_req stays 0 for 20 cycles until rst.
- Mid-MEM reset: assert rst while mem_req=1 → mem_req=0 on the next edge, PC=RESET_PC; retire_cnt=0 when CTRL_RETIRE_CNT_EN is defined.

Source files
------------

// File: rtl/ctrl_decode_fsm.sv
// ctrl_decode_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB controller producing ALU fs codes and datapath controls.
// Optional retire counter output retire_cnt is enabled by defining CTRL_RETIRE_CNT_EN.
module ctrl_decode_fsm #(
  parameter int PC_WIDTH = 8,
  parameter int nBit = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                instr_req,
  output logic [PC_WIDTH-1:0] instr_addr,
  input  logic                instr_valid,
  input  logic [nBit-1:0]     instr_in,
  output logic [2:0]          fs,
  output logic [2:0]          rd_addr,
  output logic [2:0]          rs_addr,
  output logic [2:0]          rt_addr,
  output logic [nBit-1:0]     imm,
  output logic [1:0]          wb_sel,
  output logic                reg_we,
  output logic                mem_req,
  output logic                mem_we,
  input  logic                mem_ready,
  input  logic                alu_zero,
  output logic                halted,
  output logic                illegal
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0]         retire_cnt
`endif
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state;
  logic [nBit-1:0] ir;
  logic [PC_WIDTH-1:0] pc;
  logic [nBit-1:0] imm_x;
  logic [3:0] op;
  logic is_alu, is_ldi, is_ld, is_st, is_jmp, is_bz, is_halt, legal;
  logic [2:0] fs_d;
  assign op      = ir[15:12];
  assign is_alu  = op >= 4'h1 && op <= 4'h6;
  assign is_ldi  = op == 4'h7;
  assign is_ld   = op == 4'h8;
  assign is_st   = op == 4'h9;
  assign is_jmp  = op == 4'hA;
  assign is_bz   = op == 4'hB;
  assign is_halt = op == 4'hF;
  assign legal   = op <= 4'hB || is_halt;
  assign imm_x   = {{(nBit-8){1'b0}}, ir[7:0]};
  // BZ routes the tested register through the ALU as OR(r,r) so alu_zero reflects it
  assign fs_d    = is_alu ? 3'(op - 4'd1) : is_bz ? 3'b011 : 3'b000;
  assign instr_addr = pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      instr_req <= 1'b0;
      fs        <= '0;
      rd_addr   <= '0;
      rs_addr   <= '0;
      rt_addr   <= '0;
      imm       <= '0;
      wb_sel    <= '0;
      reg_we    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      case (state)
        FETCH: begin
          if (!instr_req) instr_req <= 1'b1;
          else if (instr_valid) begin
            ir        <= instr_in;
            pc        <= pc + PC_WIDTH'(1);
            instr_req <= 1'b0;
            state     <= DECODE;
          end
        end
        DECODE: begin
          rd_addr <= ir[11:9];
          rs_addr <= is_bz ? ir[11:9] : ir[8:6];
          rt_addr <= is_bz ? ir[11:9] : ir[5:3];
          imm     <= imm_x;
          fs      <= fs_d;
          wb_sel  <= is_ldi ? 2'b01 : is_ld ? 2'b10 : 2'b00;
          state   <= EXEC;
        end
        EXEC: begin
          if (is_alu || is_ldi) begin
            reg_we <= 1'b1;
            state  <= WB;
          end else if (is_ld || is_st) begin
            mem_req <= 1'b1;
            mem_we  <= is_st;
            state   <= MEM;
          end else if (is_halt) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            instr_req <= 1'b1;
            state     <= FETCH;
          end
          if (is_jmp || (is_bz && alu_zero)) pc <= imm_x[PC_WIDTH-1:0];
          if (!legal) illegal <= 1'b1;
        end
        MEM: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            reg_we    <= is_ld;
            instr_req <= is_st;
            state     <= is_ld ? WB : FETCH;
          end
        end
        WB: begin
          instr_req <= 1'b1;
          state     <= FETCH;
        end
        default: ;
      endcase
    end
  end
`ifdef CTRL_RETIRE_CNT_EN
  logic retire;
  assign retire = (state == EXEC && !(is_alu || is_ldi || is_ld || is_st)) ||
                  (state == MEM && mem_ready && is_st) || state == WB;
  always_ff @(posedge clk) retire_cnt <= rst ? '0 : retire_cnt + 16'(retire);
`endif
endmodule

// File: tb/tb_ctrl_decode_fsm.sv
// tb_ctrl_decode_fsm: randomized instruction stream checked against an instruction-level reference model.
module tb_ctrl_decode_fsm;
  logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, mem_ready = 1'b0, alu_zero = 1'b0;
  logic [15:0] instr_in = '0;
  logic instr_req, reg_we, mem_req, mem_we, halted, illegal;
  logic [7:0] instr_addr;
  logic [2:0] fs, rd_addr, rs_addr, rt_addr;
  logic [15:0] imm;
  logic [1:0] wb_sel;
  logic [15:0] ret_obs;
`ifdef CTRL_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
  assign ret_obs = retire_cnt;
`else
  assign ret_obs = '0;
`endif
  int vectors = 0, miscompares = 0;
  logic [7:0] pc_m = '0;
  logic ill_m = 1'b0;
  logic [15:0] ret_m = '0;
  always #5 clk = ~clk;
  ctrl_decode_fsm dut (
    .clk(clk), .rst(rst), .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_in(instr_in), .fs(fs), .rd_addr(rd_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .wb_sel(wb_sel),
    .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .halted(halted), .illegal(illegal)
`ifdef CTRL_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );
  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pc_m = '0;
    ill_m = 1'b0;
    ret_m = '0;
  endtask
  // One full instruction: fetch handshake, then observe until the next fetch request or halt.
  task automatic run_instr(input logic [15:0] ins, input int fw, input int mw, input logic z);
    logic [3:0] op;
    int k, we_n, mq_n, cpi;
    logic [2:0] g_fs, g_rs, g_rt, g_rd, e_fs, e_rs, e_rt;
    logic [15:0] g_imm;
    logic [1:0] g_sel, e_sel;
    logic g_mwe;
    bit alu, mem, wb;
    op = ins[15:12];
    alu = op inside {[4'h1:4'h6]};
    mem = op inside {4'h8, 4'h9};
    wb = alu || op inside {4'h7, 4'h8};
    cpi = op == 4'h8 ? 5 + mw : op == 4'h9 ? 4 + mw : wb ? 4 : 3;
    e_fs = alu ? 3'(op - 4'd1) : op == 4'hB ? 3'b011 : 3'b000;
    e_rs = op == 4'hB ? ins[11:9] : ins[8:6];
    e_rt = op == 4'hB ? ins[11:9] : ins[5:3];
    e_sel = op == 4'h7 ? 2'b01 : op == 4'h8 ? 2'b10 : 2'b00;
    alu_zero = z;
    k = 0;
    while (instr_req !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (instr_req !== 1'b1 || instr_addr !== pc_m) begin
      miscompares++;
      $display("FAIL fetch_addr op=%h got req=%b addr=%h exp req=1 addr=%h", op, instr_req, instr_addr, pc_m);
    end
    repeat (fw) @(negedge clk);
    instr_valid = 1'b1;
    instr_in = ins;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_in = 16'($urandom);
    k = 1; we_n = 0; mq_n = 0;
    g_fs = '0; g_rs = '0; g_rt = '0; g_rd = '0; g_imm = '0; g_sel = '0; g_mwe = 1'b0;
    while (k < 60 && instr_req !== 1'b1 && halted !== 1'b1) begin
      if (k == 2) {g_fs, g_rs, g_rt, g_imm} = {fs, rs_addr, rt_addr, imm};
      if (reg_we === 1'b1) begin
        we_n++;
        g_sel = wb_sel;
        g_rd = rd_addr;
      end
      if (mem_req === 1'b1) begin
        mq_n++;
        g_mwe = mem_we;
      end
      mem_ready = (mem_req === 1'b1) && (mq_n > mw);
      @(negedge clk);
      k++;
    end
    mem_ready = 1'b0;
    pc_m = pc_m + 8'd1;
    if (op == 4'hA || (op == 4'hB && z)) pc_m = ins[7:0];
    if (op inside {[4'hC:4'hE]}) ill_m = 1'b1;
    ret_m = ret_m + 16'd1;
    vectors++;
    if (k !== cpi) begin miscompares++; $display("FAIL cycles ins=%h got %0d exp %0d", ins, k, cpi); end
    vectors++;
    if (we_n !== (wb ? 1 : 0)) begin miscompares++; $display("FAIL reg_we_count ins=%h got %0d exp %0d", ins, we_n, wb ? 1 : 0); end
    vectors++;
    if (mq_n !== (mem ? mw + 1 : 0)) begin miscompares++; $display("FAIL mem_req_cycles ins=%h got %0d exp %0d", ins, mq_n, mem ? mw + 1 : 0); end
    vectors++;
    if (g_fs !== e_fs) begin miscompares++; $display("FAIL fs ins=%h got %h exp %h", ins, g_fs, e_fs); end
    vectors++;
    if (g_imm !== {8'h00, ins[7:0]}) begin miscompares++; $display("FAIL imm ins=%h got %h exp %h", ins, g_imm, {8'h00, ins[7:0]}); end
    if (alu || mem || op == 4'hB) begin
      vectors++;
      if (g_rs !== e_rs) begin miscompares++; $display("FAIL rs_addr ins=%h got %h exp %h", ins, g_rs, e_rs); end
    end
    if (alu || op == 4'h9 || op == 4'hB) begin
      vectors++;
      if (g_rt !== e_rt) begin miscompares++; $display("FAIL rt_addr ins=%h got %h exp %h", ins, g_rt, e_rt); end
    end
    if (wb) begin
      vectors++;
      if ({g_sel, g_rd} !== {e_sel, ins[11:9]}) begin
        miscompares++;
        $display("FAIL wb ins=%h got sel=%h rd=%h exp sel=%h rd=%h", ins, g_sel, g_rd, e_sel, ins[11:9]);
      end
    end
    if (mem) begin
      vectors++;
      if (g_mwe !== (op == 4'h9)) begin miscompares++; $display("FAIL mem_we ins=%h got %b exp %b", ins, g_mwe, op == 4'h9); end
    end
    vectors++;
    if ({illegal, halted} !== {ill_m, op == 4'hF}) begin
      miscompares++;
      $display("FAIL flags ins=%h got ill=%b halt=%b exp ill=%b halt=%b", ins, illegal, halted, ill_m, op == 4'hF);
    end
    if (op != 4'hF) begin
      vectors++;
      if (instr_addr !== pc_m) begin miscompares++; $display("FAIL next_pc ins=%h got %h exp %h", ins, instr_addr, pc_m); end
    end
`ifdef CTRL_RETIRE_CNT_EN
    vectors++;
    if (ret_obs !== ret_m) begin miscompares++; $display("FAIL retire_cnt ins=%h got %0d exp %0d", ins, ret_obs, ret_m); end
`endif
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({instr_req, instr_addr, fs, rd_addr, rs_addr, rt_addr, imm, wb_sel, reg_we, mem_req, mem_we, halted, illegal, ret_obs} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got req=%b addr=%h halt=%b ill=%b exp all zero", instr_req, instr_addr, halted, illegal);
    end
    rst = 1'b0;
    pc_m = '0; ill_m = 1'b0; ret_m = '0;
    @(negedge clk);
    vectors++;
    if ({instr_req, instr_addr, reg_we, mem_req, halted, illegal} !== {1'b1, 8'h00, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_release got req=%b addr=%h exp req=1 addr=00", instr_req, instr_addr);
    end
  endtask
  task automatic test_add();
    run_instr(16'h1298, 0, 0, 1'b0);
  endtask
  task automatic test_ld();
    run_instr(16'h8940, 0, 3, 1'b0);
  endtask
  task automatic test_bz();
    run_instr(16'hB440, 0, 0, 1'b1);
    run_instr(16'hB440, 0, 0, 1'b0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 80; i++)
      run_instr({4'($urandom_range(0, 14)), 12'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
  endtask
  task automatic test_illegal_halt();
    run_instr(16'hC000, 0, 0, 1'b0);
    run_instr(16'hF000, 1, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if ({instr_req, mem_req, halted, illegal} !== 4'b0011) begin
        miscompares++;
        $display("FAIL halt_hold cyc=%0d got req=%b mreq=%b halt=%b ill=%b exp 0 0 1 1", i, instr_req, mem_req, halted, illegal);
      end
    end
  endtask
  task automatic test_mid_mem_reset();
    int k;
    do_reset();
    run_instr(16'h0000, 0, 0, 1'b0);
    k = 0;
    while (instr_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    instr_valid = 1'b1;
    instr_in = 16'h9168;
    @(negedge clk);
    instr_valid = 1'b0;
    k = 0;
    while (mem_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    vectors++;
    if (mem_req !== 1'b1) begin miscompares++; $display("FAIL mem_req_reach got %b exp 1", mem_req); end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, instr_req, instr_addr, ret_obs} !== '0) begin
      miscompares++;
      $display("FAIL mid_mem_reset got mreq=%b req=%b addr=%h ret=%0d exp all zero", mem_req, instr_req, instr_addr, ret_obs);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_add();
    test_ld();
    test_bz();
    test_random();
    test_illegal_halt();
    test_mid_mem_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1);
  end
endmodule
